// File: rtl/note_tone_synth.sv
// note_tone_synth: decodes a one-hot fret/string note word into a decaying square-wave tone.
// Ports: clk/resetn, enable/play_en/note_in strobe, codec allowed/write + L/R samples, note_idx, active.
module note_tone_synth #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter logic [31:0] AMP_MAX     = 32'h0FFF_FFFF,
  parameter logic [31:0] AMP_MIN     = 32'h0000_1000,
  parameter int unsigned DECAY_TICKS = 1_250_000,
  parameter int unsigned DECAY_SHIFT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        play_en,
  input  logic [31:0] note_in,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic [4:0]  note_idx,
  output logic        active
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY
  } state_t;

  localparam int STR_BASE [6] = '{0, 5, 10, 15, 19, 24};
  localparam logic [31:0] DECAY_LAST = 32'(DECAY_TICKS - 1);

  // Low E is 82.407 Hz; each semitone scales by 2^(1/12).
  function automatic logic [18:0] half_period(input int n);
    real f;
    f = 82.407;
    for (int i = 0; i < n; i++) f = f * 1.0594630943592953;
    return 19'($rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5));
  endfunction

  logic [18:0] half_rom [29];

  for (genvar g = 0; g < 29; g++) begin : g_rom
    localparam logic [18:0] HP = half_period(g);
    assign half_rom[g] = HP;
  end

  state_t      state_q, state_d;
  logic [4:0]  pend_q, pend_d;
  logic [4:0]  idx_d;
  logic [18:0] phase_q, phase_d;
  logic [31:0] decay_q, decay_d;
  logic [31:0] amp_q, amp_d;
  logic [31:0] amp_dec;
  logic        pol_q, pol_d;
  logic [31:0] sample_d;
  logic [4:0]  n_dec;
  logic        note_hit;
  logic        unused_hi;

  assign unused_hi = ^note_in[31:30];
  assign active    = (state_q == S_PLAY);

  // Lowest set bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    n_dec    = '0;
    note_hit = 1'b0;
    for (int i = 29; i >= 0; i--) begin
      if (note_in[i]) begin
        note_hit = 1'b1;
        n_dec    = 5'(STR_BASE[i % 6] + i / 6);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    idx_d    = note_idx;
    phase_d  = phase_q;
    decay_d  = decay_q;
    amp_d    = amp_q;
    pol_d    = pol_q;
    amp_dec  = amp_q - (amp_q >> DECAY_SHIFT);
    sample_d = '0;
    if (!play_en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable && note_hit) begin
            state_d = S_LOAD;
            pend_d  = n_dec;
          end
        end
        S_LOAD: begin
          state_d = S_PLAY;
          idx_d   = pend_q;
          phase_d = half_rom[pend_q] - 19'd1;
          amp_d   = AMP_MAX;
          pol_d   = 1'b1;
          decay_d = DECAY_LAST;
        end
        S_PLAY: begin
          if (phase_q == '0) begin
            phase_d = half_rom[note_idx] - 19'd1;
            pol_d   = ~pol_q;
          end else begin
            phase_d = phase_q - 19'd1;
          end
          if (decay_q == '0) begin
            decay_d = DECAY_LAST;
            amp_d   = amp_dec;
          end else begin
            decay_d = decay_q - 32'd1;
          end
          if (enable && note_hit) begin
            state_d = S_LOAD;
            pend_d  = n_dec;
          end else if (enable) begin
            state_d = S_IDLE;
          end else if (decay_q == '0 && amp_dec < AMP_MIN) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Output register holds the sample of the state being entered.
    if (state_d == S_PLAY) sample_d = pol_d ? amp_d : -amp_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q                 <= S_IDLE;
      pend_q                  <= '0;
      note_idx                <= '0;
      phase_q                 <= '0;
      decay_q                 <= '0;
      amp_q                   <= '0;
      pol_q                   <= 1'b0;
      write_audio_out         <= 1'b0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else begin
      state_q                 <= state_d;
      pend_q                  <= pend_d;
      note_idx                <= idx_d;
      phase_q                 <= phase_d;
      decay_q                 <= decay_d;
      amp_q                   <= amp_d;
      pol_q                   <= pol_d;
      write_audio_out         <= audio_out_allowed;
      left_channel_audio_out  <= sample_d;
      right_channel_audio_out <= sample_d;
    end
  end

endmodule

// File: tb/tb_note_tone_synth.sv
// tb_note_tone_synth: decode vectors, hand sequences and random traffic
// checked every cycle against a time-based tone model.
module tb_note_tone_synth;

  localparam int          CLK     = 100_000;
  localparam int          DT      = 16;
  localparam logic [31:0] AMP_MAX = 32'h0FFF_FFFF;
  localparam logic [31:0] AMP_MIN = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        play_en = 1'b0;
  logic [31:0] note_in = '0;
  logic        audio_out_allowed = 1'b0;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic [4:0]  note_idx;
  logic        active;

  note_tone_synth #(
    .CLK_HZ(CLK),
    .AMP_MAX(AMP_MAX),
    .AMP_MIN(AMP_MIN),
    .DECAY_TICKS(DT),
    .DECAY_SHIFT(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .play_en(play_en),
    .note_in(note_in),
    .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .note_idx(note_idx),
    .active(active)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int sb_fail = 0;
  bit chk_on = 0;

  int          halftab [29];
  logic [31:0] amptab [128];
  int          kend;

  // Tone model: mode 0 idle, 1 load, 2 play; play position m_j in cycles.
  int          m_mode = 0;
  int          m_j = 0;
  int          m_n = 0;
  int          m_idx = 0;
  int          m_pend = 0;
  logic        m_wr = 1'b0;

  function automatic logic [5:0] decode(input logic [31:0] w);
    int base [6] = '{0, 5, 10, 15, 19, 24};
    for (int k = 0; k < 30; k++) begin
      if (w[k]) return {1'b1, 5'(base[k % 6] + k / 6)};
    end
    return 6'd0;
  endfunction

  function automatic logic [31:0] exp_sample();
    logic [31:0] a;
    if (m_mode != 2) return '0;
    a = amptab[m_j / DT];
    if (((m_j / halftab[m_n]) % 2) == 0) return a;
    return -a;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode <= 0;
      m_j    <= 0;
      m_n    <= 0;
      m_idx  <= 0;
      m_pend <= 0;
      m_wr   <= 1'b0;
    end else begin
      m_wr <= audio_out_allowed;
      if (!play_en) begin
        m_mode <= 0;
      end else if (m_mode == 1) begin
        m_mode <= 2;
        m_j    <= 0;
        m_n    <= m_pend;
        m_idx  <= m_pend;
      end else if (enable && decode(note_in)[5]) begin
        m_mode <= 1;
        m_pend <= int'(decode(note_in)[4:0]);
      end else if (enable && m_mode == 2) begin
        m_mode <= 0;
      end else if (m_mode == 2) begin
        m_j <= m_j + 1;
        if (m_j + 1 >= kend * DT) m_mode <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && sb_fail < 20) begin
      logic [70:0] e, a;
      e = {m_wr, exp_sample(), exp_sample(), 5'(m_idx), m_mode == 2};
      a = {write_audio_out, left_channel_audio_out,
           right_channel_audio_out, note_idx, active};
      tests++;
      if (a !== e) begin
        fails++;
        sb_fail++;
        $display("FAIL scoreboard t=%0t got %h expected %h", $time, a, e);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [31:0] w);
    note_in = w;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
  endtask

  task automatic meas_half(output int cnt);
    cnt = 1;
    while (!left_channel_audio_out[31] && cnt < 5000) begin
      tick();
      if (!left_channel_audio_out[31]) cnt++;
    end
  endtask

  typedef struct {
    logic [31:0] note;
    logic [4:0]  idx;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cnt;
    vecs[0] = '{32'h0000_0001, 5'd0};
    vecs[1] = '{32'h0800_0000, 5'd19};
    vecs[2] = '{32'h0000_0101, 5'd0};
    vecs[3] = '{32'h0000_0001, 5'd0};
    vecs[4] = '{32'h0000_0020, 5'd24};
    vecs[5] = '{32'h2000_0000, 5'd28};
    vecs[6] = '{32'h0000_2000, 5'd7};
    vecs[7] = '{32'hC000_0008, 5'd15};

    for (int n = 0; n < 29; n++)
      halftab[n] = $rtoi(real'(CLK) /
                   (2.0 * 82.407 * $pow(2.0, real'(n) / 12.0)) + 0.5);
    amptab[0] = AMP_MAX;
    kend = 0;
    while (amptab[kend] >= AMP_MIN && kend < 127) begin
      amptab[kend + 1] = amptab[kend] - (amptab[kend] >> 3);
      kend++;
    end

    audio_out_allowed = 1'b1;
    tick();
    chk_on = 1;
    tick();
    check("reset_write", 64'(write_audio_out), 64'd0);
    check("reset_left", 64'(left_channel_audio_out), 64'd0);
    resetn  = 1'b1;
    play_en = 1'b1;
    tick();
    check("idle_write", 64'(write_audio_out), 64'd1);
    check("idle_sample", 64'(left_channel_audio_out), 64'd0);

    for (int v = 0; v < 8; v++) begin
      strobe(vecs[v].note);
      check("load_not_active", 64'(active), 64'd0);
      tick();
      check("vec_idx", 64'(note_idx), 64'(vecs[v].idx));
      check("vec_first", 64'(left_channel_audio_out), 64'(AMP_MAX));
      check("vec_right", 64'(right_channel_audio_out), 64'(AMP_MAX));
      meas_half(cnt);
      check("vec_half", 64'(cnt), 64'(halftab[vecs[v].idx]));
    end

    strobe(32'h0);
    check("rest_active", 64'(active), 64'd0);
    check("rest_sample", 64'(left_channel_audio_out), 64'd0);

    strobe(32'h40);
    tick();
    for (int i = 0; i < DT; i++) tick();
    check("decay_one", 64'(left_channel_audio_out), 64'h0E00_0000);
    cnt = DT + 1;
    while (active && cnt < 5000) begin
      tick();
      if (active) cnt++;
    end
    check("tone_len", 64'(cnt), 64'(kend * DT));
    check("end_sample", 64'(left_channel_audio_out), 64'd0);
    check("end_idx", 64'(note_idx), 64'd1);

    audio_out_allowed = 1'b0;
    check("allow_lag", 64'(write_audio_out), 64'd1);
    tick();
    check("allow_low", 64'(write_audio_out), 64'd0);
    audio_out_allowed = 1'b1;
    tick();
    check("allow_high", 64'(write_audio_out), 64'd1);

    strobe(32'h20);
    play_en = 1'b0;
    tick();
    check("pe_load_active", 64'(active), 64'd0);
    check("pe_load_sample", 64'(left_channel_audio_out), 64'd0);
    check("pe_load_idx", 64'(note_idx), 64'd1);
    play_en = 1'b1;
    tick();
    check("pe_load_stay", 64'(active), 64'd0);

    for (int c = 0; c < 9000; c++) begin
      int r;
      enable = ($urandom_range(0, 899) == 0);
      r = $urandom_range(0, 5);
      if (r == 0) note_in = '0;
      else if (r == 1)
        note_in = (32'h1 << $urandom_range(0, 29)) |
                  (32'h1 << $urandom_range(0, 29));
      else
        note_in = (32'h1 << $urandom_range(0, 29)) |
                  (32'($urandom_range(0, 3)) << 30);
      play_en = ($urandom_range(0, 1999) != 0);
      audio_out_allowed = 1'($urandom_range(0, 1));
      tick();
    end
    enable  = 1'b0;
    play_en = 1'b1;
    audio_out_allowed = 1'b1;

    strobe(32'h1);
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_active", 64'(active), 64'd1);
    resetn = 1'b0;
    #1;
    check("rst_active", 64'(active), 64'd0);
    check("rst_left", 64'(left_channel_audio_out), 64'd0);
    check("rst_right", 64'(right_channel_audio_out), 64'd0);
    check("rst_idx", 64'(note_idx), 64'd0);
    check("rst_write", 64'(write_audio_out), 64'd0);
    tick();
    tick();
    check("rst_hold_write", 64'(write_audio_out), 64'd0);
    resetn = 1'b1;
    tick();
    check("post_rst_write", 64'(write_audio_out), 64'd1);
    check("post_rst_active", 64'(active), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
